// File: rtl/uart_imem_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_imem_loader
//
// Boot loader. It receives a program image over a UART line (8N1, LSB first)
// and writes the image into instruction memory one 32-bit word at a time. The
// core is held in stall until a complete image has been written.
//
// Image format: a sync byte 0xA5, then 4*NUM_WORDS data bytes. Each group of
// four bytes forms one little-endian word. Word k is written to byte address 4*k.
//
// Optional feature (macro LOADER_CHECKSUM_EN): one extra byte follows the
// image. It must equal the XOR of all data bytes. On a mismatch, frame_err is
// set and the loader waits for a new sync byte.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit
//   NUM_WORDS     instruction words per image
//
// Ports
//   CLK        in   clock; all state changes on its rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   UART serial data, asynchronous to CLK, idle high
//   imem_we    out  instruction memory write strobe (one cycle per word)
//   imem_addr  out  instruction memory byte address (32 bits)
//   imem_wd    out  instruction memory write data (32 bits)
//   core_hold  out  high while the core must stay stalled (every state but DONE)
//   load_done  out  high once a complete image has been written
//   frame_err  out  sticky error flag (bad stop bit or bad checksum)
// -----------------------------------------------------------------------------
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int NUM_WORDS    = 20
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_hold,
    output logic        load_done,
    output logic        frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    // ---------------------------------------------------------------------
    // rx synchronizer. rx_prev_q is one stage further back and is used only
    // to detect the falling edge of the start bit. A line that stays low
    // after a framing error therefore cannot start new bytes over and over.
    // ---------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------------------------------------------------------------
    // UART receiver
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             byte_vld;   // stop bit sampled high: shreg_q holds a byte
    logic             byte_err;   // stop bit sampled low

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_vld   = 1'b0;
        byte_err   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    // Start bit gone by mid-bit: treat it as a glitch.
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        bit_d      = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_vld   = rx_sync_q;
                    byte_err   = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Loader FSM
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LOAD      = 2'd1,
`ifdef LOADER_CHECKSUM_EN
        CHECK     = 2'd2,
`endif
        DONE      = 2'd3
    } ld_state_e;

    ld_state_e        ld_state_q, ld_state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic             ferr_q, ferr_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q <= WAIT_SYNC;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            wd_q       <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            ld_state_q <= ld_state_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            wd_q       <= wd_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            ferr_q     <= ferr_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        ld_state_d = ld_state_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        wd_d       = wd_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        ferr_d     = ferr_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (byte_err) begin
            ferr_d     = 1'b1;
            ld_state_d = WAIT_SYNC;
        end else begin
            case (ld_state_q)
                WAIT_SYNC, DONE: begin
                    if (byte_vld && (shreg_q == SYNC_BYTE)) begin
                        ld_state_d = LOAD;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        ferr_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = '0;
`endif
                    end
                end
                LOAD: begin
                    // The strobe cycle advances the word index. No byte can
                    // arrive in that cycle, because a byte takes many cycles.
                    // The state changes here rather than on the 4th byte, so
                    // imem_we is only ever high while in LOAD.
                    if (we_q) begin
                        if (word_idx_q == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
                            ld_state_d = CHECK;
`else
                            ld_state_d = DONE;
`endif
                        end else begin
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end else if (byte_vld) begin
                        wd_d[{byte_cnt_q, 3'b000} +: 8] = shreg_q;
                        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = csum_q ^ shreg_q;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            we_d   = 1'b1;
                            addr_d = {{(30-IDX_W){1'b0}}, word_idx_q, 2'b00};
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (byte_vld) begin
                        if (shreg_q == csum_q) begin
                            ld_state_d = DONE;
                        end else begin
                            ferr_d     = 1'b1;
                            ld_state_d = WAIT_SYNC;
                        end
                    end
                end
`endif
                default: ld_state_d = WAIT_SYNC;
            endcase
        end
    end

    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_wd   = wd_q;
    assign core_hold = (ld_state_q != DONE);
    assign load_done = (ld_state_q == DONE);
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
`timescale 1ns/1ps
// Bench for uart_imem_loader (CLKS_PER_BIT = 4, NUM_WORDS = 2).
// The stimulus process sends UART bytes. For every byte it first runs a
// byte-level model of the image rules, and that model queues each expected
// memory write. A monitor pops one entry from the queue each time imem_we is
// seen high.
module tb_uart_imem_loader;

    localparam int CPB = 4;
    localparam int NW  = 2;

    logic        CLK;
    logic        rst_n;
    logic        rx;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        core_hold;
    logic        load_done;
    logic        frame_err;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .NUM_WORDS(NW)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .core_hold (core_hold),
        .load_done (load_done),
        .frame_err (frame_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  wr_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wd   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte level) ----------------
    bit         m_loading, m_done, m_ferr;
    int         m_nwords;
    logic [7:0] m_bytes[$];

    task automatic model_reset();
        m_loading = 0;
        m_done    = 0;
        m_ferr    = 0;
        m_nwords  = 0;
        m_bytes.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        wr_t w;
        if (!ok) begin
            m_ferr    = 1;
            m_loading = 0;
            m_done    = 0;
            m_bytes.delete();
        end else if (!m_loading) begin
            if (b == 8'hA5) begin
                m_loading = 1;
                m_done    = 0;
                m_ferr    = 0;
                m_nwords  = 0;
                m_bytes.delete();
            end
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                w.addr = 32'(m_nwords * 4);
                w.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                exp_q.push_back(w);
                m_nwords++;
                m_bytes.delete();
                if (m_nwords == NW) begin
                    m_loading = 0;
                    m_done    = 1;
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (rst_n && imem_we) begin
            wr_t e;
            wr_cnt++;
            last_addr = imem_addr;
            last_wd   = imem_wd;
            chk("hold_during_write", 32'(core_hold), 32'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         imem_addr, imem_wd);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", imem_addr, e.addr);
                chk("write_data", imem_wd, e.data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        @(negedge CLK);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(ok ? 1'b1 : 1'b0);
        if (!ok) drive_bit(1'b1);
    endtask

    task automatic check_status(input string tag);
        chk({tag, ":core_hold"}, 32'(core_hold), 32'(!m_done));
        chk({tag, ":load_done"}, 32'(load_done), 32'(m_done));
        chk({tag, ":frame_err"}, 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic send_chk(input logic [7:0] b, input bit ok);
        model_byte(b, ok);
        send_byte(b, ok);
        repeat (4) @(negedge CLK);
        check_status("after_byte");
        repeat ($urandom_range(0, 3)) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst:imem_we",   32'(imem_we),   32'd0);
        chk("rst:imem_addr", imem_addr,      32'd0);
        chk("rst:imem_wd",   imem_wd,        32'd0);
        chk("rst:core_hold", 32'(core_hold), 32'd1);
        chk("rst:load_done", 32'(load_done), 32'd0);
        chk("rst:frame_err", 32'(frame_err), 32'd0);
        chk("rst:pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    // Start a byte, send three data bits, then reset in the middle of the byte.
    task automatic partial_then_reset(input logic [7:0] b);
        @(negedge CLK);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        do_reset();
    endtask

    task automatic glitch();
        @(negedge CLK);
        rx = 1'b0;
        @(negedge CLK);
        rx = 1'b1;
        repeat (20) @(negedge CLK);
        check_status("after_glitch");
    endtask

    // ---------------- main sequence ----------------
    int wr_base;

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        model_reset();
        do_reset();

        // Idle line: no writes, core held.
        repeat (100) @(negedge CLK);
        check_status("idle");
        glitch();

        // Reference image.
        send_chk(8'hA5, 1);
        send_chk(8'h13, 1); send_chk(8'h00, 1); send_chk(8'h00, 1); send_chk(8'h00, 1);
        chk("img1:word0_addr", last_addr, 32'h0);
        chk("img1:word0_data", last_wd,   32'h0000_0013);
        send_chk(8'h93, 1); send_chk(8'h00, 1); send_chk(8'h10, 1); send_chk(8'h00, 1);
        chk("img1:word1_addr", last_addr, 32'h4);
        chk("img1:word1_data", last_wd,   32'h0010_0093);
        chk("img1:write_count", 32'(wr_cnt), 32'd2);
        chk("img1:load_done", 32'(load_done), 32'd1);
        chk("img1:core_hold", 32'(core_hold), 32'd0);

        // In DONE: other bytes and glitches are ignored, and 0xA5 restarts loading.
        glitch();
        send_chk(8'h00, 1);
        send_chk(8'hA5, 1);
        chk("reload:core_hold", 32'(core_hold), 32'd1);

        // Framing error during LOAD, then data bytes without a sync byte.
        send_chk(8'h11, 1);
        glitch();
        send_chk(8'h55, 0);
        chk("ferr:frame_err", 32'(frame_err), 32'd1);
        wr_base = wr_cnt;
        send_chk(8'h13, 1); send_chk(8'h00, 1); send_chk(8'h00, 1); send_chk(8'h00, 1);
        chk("ferr:no_writes", 32'(wr_cnt - wr_base), 32'd0);

        // Reset mid-image, then a fresh image. The first write must hold only new data.
        send_chk(8'hA5, 1);
        send_chk(8'hDE, 1); send_chk(8'hAD, 1);
        do_reset();
        wr_base = wr_cnt;
        send_chk(8'hA5, 1);
        send_chk(8'h01, 1); send_chk(8'h02, 1); send_chk(8'h03, 1); send_chk(8'h04, 1);
        chk("rst_img:write_count", 32'(wr_cnt - wr_base), 32'd1);
        chk("rst_img:addr", last_addr, 32'h0);
        chk("rst_img:data", last_wd,   32'h0403_0201);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 9))
                0: send_chk(8'($urandom), 1'b1);
                1: send_chk(8'($urandom), 1'b0);
                2: do_reset();
                3: partial_then_reset(8'($urandom));
                default: begin
                    send_chk(8'hA5, 1'b1);
                    for (int k = 0; k < 4 * NW; k++) begin
                        send_chk(8'($urandom), ($urandom_range(0, 24) != 0));
                    end
                end
            endcase
        end

        repeat (10) @(negedge CLK);
        chk("end:pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
